// File: rtl/gemm_pkg.sv
// Shared widths and pipeline constants for the GEMM datapath blocks.
// Stage side-band travels alongside the data so every stage can hold on a stall.
package gemm_pkg;
  localparam int GEMM_INP_WIDTH = 8;
  localparam int GEMM_WGT_WIDTH = 8;
  localparam int GEMM_ACC_WIDTH = 32;
  localparam int GEMM_LANES     = 16;
  localparam int DOT_PIPE_LAT   = 3;

  typedef struct packed {
    logic vld;
    logic clr;
  } stage_ctl_t;
endpackage

// File: rtl/dot_mul_lane.sv
// One registered signed multiplier lane; the product is sign-extended
// (or wrapped) to the accumulator width and held while i_en is low.
module dot_mul_lane #(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [INP_WIDTH-1:0] i_inp,
  input  logic [WGT_WIDTH-1:0] i_wgt,
  output logic [ACC_WIDTH-1:0] o_prod
);
  localparam int PW = INP_WIDTH + WGT_WIDTH;

  logic signed [PW-1:0] w_prod_full;
  logic [ACC_WIDTH-1:0] r_prod;

  // Full-precision product; the size casts keep the operands signed.
  assign w_prod_full = PW'($signed(i_inp)) * PW'($signed(i_wgt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= ACC_WIDTH'(w_prod_full);
    end
  end

  assign o_prod = r_prod;
endmodule

// File: rtl/dot_mac_pipe.sv
// Three-stage dot-product MAC: lane products, adder-tree total, then
// accumulate/clear into sum_out. One stall signal freezes all stages together.
module dot_mac_pipe
  import gemm_pkg::*;
#(
  parameter int INP_WIDTH = GEMM_INP_WIDTH,
  parameter int WGT_WIDTH = GEMM_WGT_WIDTH,
  parameter int ACC_WIDTH = GEMM_ACC_WIDTH,
  parameter int LANES     = GEMM_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*INP_WIDTH-1:0] inp,
  input  logic [LANES*WGT_WIDTH-1:0] wgt,
  input  logic [ACC_WIDTH-1:0]       acc_in,
  input  logic                       acc_rst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       sum_out
);
  localparam int LVLS = $clog2(LANES);

  logic                 w_stall;
  logic [ACC_WIDTH-1:0] w_prod [LANES];
  logic [ACC_WIDTH-1:0] w_tot;

  stage_ctl_t           r_s1;
  stage_ctl_t           r_s2;
  logic [ACC_WIDTH-1:0] r_s1_acc;
  logic [ACC_WIDTH-1:0] r_s2_acc;
  logic [ACC_WIDTH-1:0] r_s2_dot;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_sum_out;

  // Stall depends only on registered out_valid and out_ready, never in_valid.
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = rst || !w_stall;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dot_mul_lane #(
      .INP_WIDTH(INP_WIDTH),
      .WGT_WIDTH(WGT_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_en  (!w_stall),
      .i_inp (inp[i*INP_WIDTH +: INP_WIDTH]),
      .i_wgt (wgt[i*WGT_WIDTH +: WGT_WIDTH]),
      .o_prod(w_prod[i])
    );
  end

  // Binary reduction: level l holds LANES>>l partial sums.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [ACC_WIDTH-1:0] w_node [LANES>>l];
    for (genvar n = 0; n < (LANES >> l); n++) begin : g_node
      if (l == 0) begin : g_leaf
        assign w_node[n] = w_prod[n];
      end else begin : g_add
        assign w_node[n] = g_lvl[l-1].w_node[2*n] + g_lvl[l-1].w_node[2*n+1];
      end
    end
  end

  assign w_tot = g_lvl[LVLS].w_node[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1.vld <= 1'b0;
      r_s1.clr <= 1'b0;
      r_s1_acc <= '0;
    end else if (!w_stall) begin
      r_s1.vld <= in_valid;
      r_s1.clr <= acc_rst;
      r_s1_acc <= acc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2.vld <= 1'b0;
      r_s2.clr <= 1'b0;
      r_s2_acc <= '0;
      r_s2_dot <= '0;
    end else if (!w_stall) begin
      r_s2     <= r_s1;
      r_s2_acc <= r_s1_acc;
      r_s2_dot <= w_tot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum_out   <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_s2.vld;
      if (r_s2.vld) begin
        r_sum_out <= r_s2.clr ? '0 : r_s2_acc + r_s2_dot;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum_out   = r_sum_out;
endmodule

// File: doc/dot_mac_pipe.md
DOT_MAC_PIPE -- requirements
Module: dot_mac_pipe

Interface
REQ-001 SHALL have parameter INP_WIDTH, default 8, signed input element width.
REQ-002 SHALL have parameter WGT_WIDTH, default 8, signed weight element width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, accumulator/result width.
REQ-004 SHALL have parameter LANES, default 16, elements per dot product (power of two, 1..64).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port in_valid  input  1  input transaction present.
REQ-008 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port inp  input  LANES*INP_WIDTH  packed input vector, lane i at bits [i*INP_WIDTH +: INP_WIDTH].
REQ-010 SHALL have port wgt  input  LANES*WGT_WIDTH  packed weight vector, same lane packing.
REQ-011 SHALL have port acc_in  input  ACC_WIDTH  accumulator operand.
REQ-012 SHALL have port acc_rst  input  1  per-transaction clear: result forced to zero.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port sum_out  output  ACC_WIDTH  result.

Function
REQ-016 SHALL compute sum_out = acc_in + sum over i of (signed inp[i] * signed wgt[i]), all operands sign-extended to ACC_WIDTH, modulo 2^ACC_WIDTH (wrap, no saturation).
REQ-017 SHALL produce sum_out = 0 when the transaction was accepted with acc_rst=1, regardless of inp, wgt, acc_in.
REQ-018 SHALL accept a transaction on a cycle where in_valid && in_ready; acc_rst and acc_in sampled with it.
REQ-019 SHALL be a 3-stage pipeline: S1 registers LANES products; S2 registers adder-tree total; S3 registers acc add/clear into sum_out.
REQ-020 SHALL present a transaction accepted at edge t on out_valid/sum_out after edge t+3 when no stall occurs.
REQ-021 SHALL sustain one transaction per cycle when out_ready stays high.
REQ-022 SHALL hand off a result on a cycle where out_valid && out_ready.
REQ-023 SHALL stall all stages together when out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
REQ-024 SHALL hold sum_out and out_valid stable while stalled; no result dropped, duplicated or reordered.
REQ-025 SHALL carry a valid bit per stage; bubbles advance when not stalled so in-flight results drain.
REQ-026 SHALL accept and retire simultaneously (out handoff and in accept same cycle) without loss.
REQ-027 SHALL keep in_ready independent of in_valid (no combinational in_valid->in_ready path).

Reset
REQ-028 SHALL on rst clear all stage valid bits; out_valid=0, sum_out=0 on the following cycle.
REQ-029 SHALL discard all in-flight transactions when rst asserts mid-operation; none emerge afterwards.
REQ-030 SHALL drive in_ready=1 during and after reset.
REQ-031 SHALL ignore in_valid on cycles where rst=1.

Structure
REQ-032 SHALL take default widths (INP/WGT/ACC) and LANES from shared package gemm_pkg; stage count constant DOT_PIPE_LAT=3 in the same package.
REQ-033 SHALL instantiate LANES copies of sub-module dot_mul_lane (one registered signed multiplier, output ACC_WIDTH, stall enable).
REQ-034 SHALL build the adder tree as a generate-loop binary reduction, combinational within S2.

Verification
REQ-035 SHALL verify: LANES=16, all inp=1, wgt=2, acc_in=5, acc_rst=0 -> sum_out=37, out_valid exactly 3 cycles after accept.
REQ-036 SHALL verify: lane0 inp=0x80, wgt=0x7F, other lanes 0, acc_in=0 -> sum_out=0xFFFFC080 (-16256).
REQ-037 SHALL verify: acc_in=0x7FFFFFFF, lane0 inp=1, wgt=1, others 0 -> sum_out=0x80000000 (wrap); same vector with acc_rst=1 -> 0.
REQ-038 SHALL verify: out_ready=0, in_valid=1 streaming A,B,C,D -> A,B,C accepted, in_ready=0 while stalled; release out_ready -> A,B,C,D emerge in order, back-to-back.
REQ-039 SHALL verify: rst pulsed with 2 transactions in flight -> out_valid=0, sum_out=0 next cycle, no stale result thereafter; new transaction after reset completes in 3 cycles.
REQ-040 SHALL verify: random vectors, random in_valid/out_ready toggling, 10000 transactions -> scoreboard matches REQ-016/017 model, count in == count out.
